// File: rtl/i_pins_conditioner.sv
// Input-pin conditioner: 2-flop synchroniser, per-bit debounce, rise/fall strobes.
// Define I_PINS_DEBOUNCE_EN for debounce counters; otherwise i_pins follows the synchroniser.
module i_pins_conditioner #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_WIDTH       = 5
) (
    input  logic             clk,
    input  logic             sync_reset,
    input  logic [WIDTH-1:0] raw_pins,
    output logic [WIDTH-1:0] i_pins,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
);

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > (1 << CNT_WIDTH)) begin : g_cfg_check
        $error("i_pins_conditioner: DEBOUNCE_CYCLES out of range for CNT_WIDTH");
    end

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] r_stable;
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_update;

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= raw_pins;
            r_s2 <= r_s1;
        end
    end

    assign w_diff = r_s2 ^ r_stable;

`ifdef I_PINS_DEBOUNCE_EN
    localparam logic [CNT_WIDTH-1:0] CntMax = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    for (genvar b = 0; b < WIDTH; b++) begin : g_debounce
        logic [CNT_WIDTH-1:0] r_cnt;

        assign w_update[b] = w_diff[b] && (r_cnt == CntMax);

        // Any agreeing sample discards the partial count, rejecting short glitches.
        always_ff @(posedge clk) begin
            if (sync_reset) begin
                r_cnt <= '0;
            end else if (!w_diff[b] || w_update[b]) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end
`else
    assign w_update = w_diff;
`endif

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            r_stable <= '0;
            r_rise   <= '0;
            r_fall   <= '0;
        end else begin
            r_stable <= r_stable ^ w_update;
            r_rise   <= w_update & r_s2;
            r_fall   <= w_update & ~r_s2;
        end
    end

    assign i_pins  = r_stable;
    assign rise    = r_rise;
    assign fall    = r_fall;
    assign changed = |(r_rise | r_fall);

endmodule

// File: doc/i_pins_conditioner.md
# i_pins_conditioner

Input conditioning stage directly upstream of the processor's `i_pins` port. Takes the four asynchronous external input pins, synchronises them into the `clk` domain, debounces each bit independently, and presents a clean 4-bit value to the computational unit. Also produces one-cycle rise/fall event strobes per bit for status display and future interrupt logic.

## Interface

Parameters:
- `WIDTH`, 4: number of input pins conditioned.
- `DEBOUNCE_CYCLES`, 16: consecutive cycles a synchronised bit must differ from its stable value before the stable value updates; legal range 1..2^`CNT_WIDTH`.
- `CNT_WIDTH`, 5: width of each per-bit debounce counter.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `sync_reset`  in  1  synchronous, active-high reset.
- `raw_pins`  in  WIDTH  asynchronous external pins.
- `i_pins`  out  WIDTH  debounced stable value; feeds the computational unit's `i_pins`.
- `rise`  out  WIDTH  per-bit one-cycle pulse on a 0→1 transition of `i_pins`.
- `fall`  out  WIDTH  per-bit one-cycle pulse on a 1→0 transition of `i_pins`.
- `changed`  out  1  OR of all `rise` and `fall` bits, same cycle.

## Operation

- Per bit b: two-flop synchroniser `s1[b]` ← `raw_pins[b]`, `s2[b]` ← `s1[b]`.
- Stable register `i_pins[b]`, counter `cnt[b]`. Each edge:
  - `s2[b] == i_pins[b]`: `cnt[b]` ← 0 (any agreeing sample discards partial count; glitch rejection).
  - `s2[b] != i_pins[b]` and `cnt[b] == DEBOUNCE_CYCLES-1`: `i_pins[b]` ← `s2[b]`, `cnt[b]` ← 0, `rise[b]` ← `s2[b]`, `fall[b]` ← ~`s2[b]`.
  - `s2[b] != i_pins[b]` otherwise: `cnt[b]` ← `cnt[b]`+1.
- `rise`/`fall` are registered, asserted in the same cycle `i_pins` first shows the new value, and cleared on the next edge. `rise[b]` and `fall[b]` are never high together.
- Bits are fully independent; simultaneous transitions on several bits each produce their own strobes in the same cycle; `changed` asserts once.
- Counter never exceeds `DEBOUNCE_CYCLES-1`; no wrap-around.
- Reset: `s1`, `s2`, `i_pins`, `cnt`, `rise`, `fall`, `changed` all 0. Reset asserted mid-count abandons the count. Pins held high through reset reach `i_pins` through the normal debounce path after release, with `rise` pulses.

## Timing

- Raw change meeting setup before edge E0: captured in `s1` at E0, `s2` at E1; `i_pins` updates at edge E(DEBOUNCE_CYCLES+1). Latency = DEBOUNCE_CYCLES+2 edges (18 with default).
- A change held in `s2` for fewer than DEBOUNCE_CYCLES consecutive edges never reaches `i_pins`.
- `changed` is combinational OR of registered `rise|fall`; no extra latency.
- `sync_reset` takes effect on the first edge it is sampled high; outputs 0 from that edge.

## Configuration

- `I_PINS_DEBOUNCE_EN` defined: debounce counters implemented as above.
- Undefined: counters removed; `i_pins` ← `s2` every edge, `rise`/`fall` registered from the `s2` vs `i_pins` difference in the same edge. Latency fixed at 3 edges; `DEBOUNCE_CYCLES`/`CNT_WIDTH` ignored. Reset values unchanged.

## Test plan

- Reset: drive `raw_pins`=4'b1010, hold `sync_reset` 3 cycles -> `i_pins`=0, `rise`=`fall`=0, `changed`=0 throughout reset.
- Clean edge, `DEBOUNCE_CYCLES`=4: `raw_pins` 0→4'b0001 before E0 -> `i_pins`=4'b0001 from E5, `rise`=4'b0001 and `changed`=1 for exactly one cycle at E5.
- Glitch, `DEBOUNCE_CYCLES`=4: bit 2 high for 3 cycles then low -> `i_pins[2]` stays 0, no `rise`/`fall`; then high for 4 cycles -> updates.
- Independent bits: bit 0 rises at E0, bit 3 falls (after settled high) at E2 -> `rise[0]` at E5, `fall[3]` at E7; `changed` pulses twice; simultaneous change of bits 1 and 2 -> both strobes same cycle, single `changed` pulse.
- Reset mid-count: bit 1 rises, assert `sync_reset` at E3 for 1 cycle -> all state 0; after release, `i_pins[1]` updates DEBOUNCE_CYCLES+2 edges after release.
- Macro undefined: `raw_pins` 0→4'b1111 before E0 -> `i_pins`=4'b1111 at E2 edge output (3 edges), one-cycle `rise`=4'b1111.
